// File: rtl/imem_stall_resp_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction
// memory responder (slave).
interface imem_stall_resp_if;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        cancel;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        err;

  modport master (
    output rd, wr, addr, data_in, cancel,
    input  data_out, done, stall, err
  );

  modport slave (
    input  rd, wr, addr, data_in, cancel,
    output data_out, done, stall, err
  );
endinterface

// File: rtl/imem_stall_resp.sv
// Multi-cycle instruction memory responder: fixed-latency reads/writes with
// stall while busy, a one-cycle done pulse and a one-cycle err pulse for
// rejected requests. All outputs are registered or decoded from state.
module imem_stall_resp #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  imem_stall_resp_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  op_wr;
  logic [ADDR_BITS-1:0]  idx;
  logic [15:0]           wdata;
  logic [15:0]           dout;
  logic                  err, err_nxt;

  logic [15:0]           mem [2**ADDR_BITS];

  // Signals describing the edge that enters DONE (read/write commit point).
  logic                  fin;
  logic                  fin_wr;
  logic [ADDR_BITS-1:0]  fin_idx;
  logic [15:0]           fin_data;

  logic                  can_accept, req_ok, req_bad;

  // Upper address bits only select aliases of the same word.
  logic                  unused_hi;
  assign unused_hi = ^bus.addr[15:ADDR_BITS+1];

  assign can_accept = (state != BUSY);
  assign req_ok     = (bus.rd ^ bus.wr) & ~bus.addr[0];
  assign req_bad    = (bus.rd | bus.wr) & ~req_ok;

  // Next state, counter, error pulse and commit decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    fin       = 1'b0;
    fin_wr    = op_wr;
    fin_idx   = idx;
    fin_data  = wdata;
    case (state)
      IDLE, DONE: begin
        if (req_ok) begin
          cnt_nxt = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            // Single-cycle latency commits straight from the request inputs.
            state_nxt = DONE;
            fin       = 1'b1;
            fin_wr    = bus.wr;
            fin_idx   = bus.addr[ADDR_BITS:1];
            fin_data  = bus.data_in;
          end else begin
            state_nxt = BUSY;
          end
        end else begin
          err_nxt   = req_bad;
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (bus.cancel) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt_nxt == 4'd0) begin
            state_nxt = DONE;
            fin       = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      err   <= 1'b0;
      dout  <= 16'h0000;
      op_wr <= 1'b0;
      idx   <= '0;
      wdata <= 16'h0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
      if (can_accept && req_ok) begin
        op_wr <= bus.wr;
        idx   <= bus.addr[ADDR_BITS:1];
        wdata <= bus.data_in;
      end
      if (fin && !fin_wr) dout <= mem[fin_idx];
    end
  end

  // Array write on DONE entry; reset drops a pending write but never clears data.
  always_ff @(posedge clk) begin
    if (!rst && fin && fin_wr) mem[fin_idx] <= fin_data;
  end

  assign bus.stall    = (state == BUSY);
  assign bus.done     = (state == DONE);
  assign bus.err      = err;
  assign bus.data_out = dout;

endmodule

// File: tb/tb_imem_stall_resp.sv
// Bench for imem_stall_resp: LATENCY=4 and LATENCY=1 instances, queue
// scoreboard of expected data_out at each done pulse plus per-scenario checks.
module tb_imem_stall_resp;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] exp_q[$];

  imem_stall_resp_if bus4();
  imem_stall_resp_if bus1();

  imem_stall_resp #(.LATENCY(4), .ADDR_BITS(8)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  imem_stall_resp #(.LATENCY(1), .ADDR_BITS(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done pulse of the LATENCY=4 instance pops one expectation.
  always @(negedge clk) begin
    if (!rst && bus4.done === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done got data_out=%h, required no done", bus4.data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus4.data_out !== e) begin
          n_fail++;
          $display("FAIL sb_data got %h required %h", bus4.data_out, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    bus4.rd = 0; bus4.wr = 0; bus4.addr = 16'h0; bus4.data_in = 16'h0; bus4.cancel = 0;
  endtask

  // Issue one request, then count stall cycles until done (bounded).
  task automatic run4(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_out, output int stalls, output int done_cyc);
    exp_q.push_back(exp_out);
    bus4.rd = r; bus4.wr = w; bus4.addr = a; bus4.data_in = d;
    step();
    idle4();
    stalls = 0;
    done_cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus4.done === 1'b1) begin
        done_cyc = i;
        break;
      end
      if (bus4.stall === 1'b1) stalls++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle4();
    bus1.rd = 0; bus1.wr = 0; bus1.addr = 16'h0; bus1.data_in = 16'h0; bus1.cancel = 0;
    step(); step();
    rst = 0;
    step();
    n_tests++;
    if ({bus4.done, bus4.stall, bus4.err, bus4.data_out} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got d=%b s=%b e=%b q=%h required all zero",
               bus4.done, bus4.stall, bus4.err, bus4.data_out);
    end
  endtask

  task automatic test_write_read();
    int s, c;
    run4(0, 1, 16'h0010, 16'hA5C3, 16'h0000, s, c);
    step();
    n_tests++;
    if (s !== 3 || c !== 4) begin
      n_fail++;
      $display("FAIL write_timing got stalls=%0d done_cycle=%0d required 3/4", s, c);
    end
    run4(1, 0, 16'h0010, 16'h0000, 16'hA5C3, s, c);
    n_tests++;
    if (s !== 3 || c !== 4) begin
      n_fail++;
      $display("FAIL read_timing got stalls=%0d done_cycle=%0d required 3/4", s, c);
    end
    step();
    n_tests++;
    if (bus4.data_out !== 16'hA5C3 || bus4.done !== 1'b0) begin
      n_fail++;
      $display("FAIL read_hold got data_out=%h done=%b required A5C3/0", bus4.data_out, bus4.done);
    end
  endtask

  task automatic test_back_to_back();
    int s, c;
    run4(0, 1, 16'h0000, 16'h1111, 16'hA5C3, s, c); step();
    run4(0, 1, 16'h0002, 16'h2222, 16'hA5C3, s, c); step();
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    bus4.rd = 1; bus4.addr = 16'h0000;
    step();
    bus4.addr = 16'h0002;
    for (int cy = 1; cy <= 8; cy++) begin
      logic ed;
      ed = (cy == 4 || cy == 8);
      n_tests++;
      if (bus4.done !== ed || bus4.stall !== !ed) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d got done=%b stall=%b required done=%b stall=%b",
                 cy, bus4.done, bus4.stall, ed, !ed);
      end
      step();
      if (cy == 4) idle4();
    end
  endtask

  task automatic test_err_misaligned();
    bus4.rd = 1; bus4.addr = 16'h0003;
    step();
    idle4();
    n_tests++;
    if (bus4.err !== 1'b1 || bus4.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL err_misaligned got err=%b stall=%b required 1/0", bus4.err, bus4.stall);
    end
    step();
    n_tests++;
    if (bus4.err !== 1'b0 || bus4.stall !== 1'b0 || bus4.done !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_end got err=%b stall=%b done=%b required 0/0/0",
               bus4.err, bus4.stall, bus4.done);
    end
    step();
  endtask

  task automatic test_err_rdwr();
    int s, c;
    bus4.rd = 1; bus4.wr = 1; bus4.addr = 16'h0010; bus4.data_in = 16'hFFFF;
    step();
    idle4();
    n_tests++;
    if (bus4.err !== 1'b1 || bus4.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL err_rdwr got err=%b stall=%b required 1/0", bus4.err, bus4.stall);
    end
    step();
    run4(1, 0, 16'h0010, 16'h0000, 16'hA5C3, s, c);
    n_tests++;
    if (c !== 4) begin
      n_fail++;
      $display("FAIL rdwr_followup got done_cycle=%0d required 4", c);
    end
    step();
  endtask

  task automatic test_wrap();
    int s, c;
    run4(0, 1, 16'h0204, 16'hBEEF, 16'hA5C3, s, c); step();
    run4(1, 0, 16'h0004, 16'h0000, 16'hBEEF, s, c);
    n_tests++;
    if (c !== 4 || bus4.data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL wrap_read got data_out=%h done_cycle=%0d required BEEF/4", bus4.data_out, c);
    end
    step();
  endtask

  task automatic test_cancel();
    bus4.rd = 1; bus4.addr = 16'h0000;
    step();
    idle4();
    step();
    bus4.cancel = 1;
    step();
    bus4.cancel = 0;
    n_tests++;
    if (bus4.stall !== 1'b0 || bus4.data_out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL cancel_drop got stall=%b data_out=%h required 0/BEEF", bus4.stall, bus4.data_out);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus4.done !== 1'b0) begin
        n_fail++;
        $display("FAIL cancel_no_done got done=%b required 0", bus4.done);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_write();
    int s, c;
    bus4.wr = 1; bus4.addr = 16'h0010; bus4.data_in = 16'h5555;
    step();
    idle4();
    step();
    rst = 1;
    step();
    rst = 0;
    n_tests++;
    if ({bus4.done, bus4.stall, bus4.err, bus4.data_out} !== 19'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got d=%b s=%b e=%b q=%h required all zero",
               bus4.done, bus4.stall, bus4.err, bus4.data_out);
    end
    step(); step(); step();
    run4(1, 0, 16'h0010, 16'h0000, 16'hA5C3, s, c);
    n_tests++;
    if (c !== 4 || bus4.data_out !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL rst_mid_word got data_out=%h done_cycle=%0d required A5C3/4", bus4.data_out, c);
    end
    step();
  endtask

  task automatic test_latency1();
    bus1.wr = 1; bus1.addr = 16'h0008; bus1.data_in = 16'h1234;
    step();
    n_tests++;
    if (bus1.done !== 1'b1 || bus1.stall !== 1'b0 || bus1.data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL lat1_write got done=%b stall=%b data_out=%h required 1/0/0000",
               bus1.done, bus1.stall, bus1.data_out);
    end
    bus1.wr = 0; bus1.rd = 1;
    step();
    bus1.rd = 0;
    n_tests++;
    if (bus1.done !== 1'b1 || bus1.stall !== 1'b0 || bus1.data_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL lat1_read got done=%b stall=%b data_out=%h required 1/0/1234",
               bus1.done, bus1.stall, bus1.data_out);
    end
    step();
    n_tests++;
    if (bus1.done !== 1'b0 || bus1.stall !== 1'b0 || bus1.data_out !== 16'h1234) begin
      n_fail++;
      $display("FAIL lat1_after got done=%b stall=%b data_out=%h required 0/0/1234",
               bus1.done, bus1.stall, bus1.data_out);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_err_misaligned();
    test_err_rdwr();
    test_wrap();
    test_cancel();
    test_reset_mid_write();
    test_latency1();
    step();
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL sb_leftover got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
